// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
//   AHB-Lite bundle between a master/multiplexor and the SRAM slave.
//   Signal names are written from the slave's point of view (_in = into
//   the slave, _out = out of the slave).
//
//   master modport : drives address/control/wdata and the HREADY that the
//                    multiplexor feeds back; observes the slave outputs.
//   slave  modport : the reverse.
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32
);
    logic                      ahb_sel_in;
    logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in;
    logic [1:0]                ahb_trans_in;
    logic                      ahb_write_in;
    logic [2:0]                ahb_size_in;
    logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in;
    logic                      ahb_ready_in;
    logic [AHB_DATA_WIDTH-1:0] slave_rdata_out;
    logic                      slave_readyout_out;
    logic                      slave_resp_out;

    modport master (
        output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in,
               ahb_size_in, ahb_wdata_in, ahb_ready_in,
        input  slave_rdata_out, slave_readyout_out, slave_resp_out
    );

    modport slave (
        input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in,
               ahb_size_in, ahb_wdata_in, ahb_ready_in,
        output slave_rdata_out, slave_readyout_out, slave_resp_out
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB-Lite on-chip SRAM slave with WAIT_STATES wait cycles per OKAY data
//   phase, byte/halfword/word writes and the two-cycle ERROR response for
//   oversized, misaligned or out-of-range transfers.
//
//   Ports:
//     ahb_clk_in   AHB clock
//     ahb_rstn_in  asynchronous active-low reset
//     bus          ahb_sram_slave_if.slave: HSEL/HADDR/HTRANS/HWRITE/HSIZE/
//                  HWDATA/HREADY in, HRDATA/HREADYOUT/HRESP out
//
//   The interface instance must be built with the same data/address widths
//   as this module.
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int WAIT_STATES    = 1
) (
    input  logic             ahb_clk_in,
    input  logic             ahb_rstn_in,
    ahb_sram_slave_if.slave  bus
);
    localparam int BYTES = AHB_DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state;
    logic              readyout_q;
    logic              resp_q;
    logic              wr_q;
    logic [IDXW-1:0]   idx_q;
    logic [BYTES-1:0]  be_q;
    logic [2:0]        cnt_q;
    logic [AHB_DATA_WIDTH-1:0] rdata_q;

    logic [BYTES-1:0][7:0] mem [MEM_DEPTH];

    // ---------------- address-phase decode ----------------
    logic             accept;
    logic             size_bad;
    logic             misal;
    logic             oob;
    logic             illegal;
    logic [BYTES-1:0] be_d;
    logic [IDXW-1:0]  idx_d;

    always_comb begin
        accept   = bus.ahb_sel_in && bus.ahb_ready_in &&
                   (bus.ahb_trans_in == 2'b10 || bus.ahb_trans_in == 2'b11);
        size_bad = bus.ahb_size_in > 3'(LSB);
        // Any address bit below the transfer size must be zero.
        misal = 1'b0;
        for (int i = 0; i < LSB; i++) begin
            if (bus.ahb_size_in > 3'(i) && bus.ahb_addr_in[i]) misal = 1'b1;
        end
        oob     = (bus.ahb_addr_in >> LSB) >= AHB_ADDR_WIDTH'(MEM_DEPTH);
        illegal = size_bad || misal || oob;
        // A lane is enabled when it falls in the same size-aligned chunk
        // as the transfer address.
        be_d = '0;
        for (int b = 0; b < BYTES; b++) begin
            be_d[b] = ((LSB'(b) >> bus.ahb_size_in) ==
                       (bus.ahb_addr_in[LSB-1:0] >> bus.ahb_size_in));
        end
        idx_d = bus.ahb_addr_in[LSB +: IDXW];
    end

    // ---------------- control FSM ----------------
    // Accepts are only evaluated in IDLE/DATA/ERR2; in WAIT/ERR1 this slave
    // is holding HREADY low so no address phase can complete.
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state      <= S_IDLE;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            be_q       <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            // Keep the last read word visible once the DATA cycle ends.
            if (state == S_DATA && !wr_q) rdata_q <= mem[idx_q];

            case (state)
                S_WAIT: begin
                    if (cnt_q == 3'(WAIT_STATES - 1)) begin
                        state      <= S_DATA;
                        readyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_ERR1: begin
                    state      <= S_ERR2;
                    readyout_q <= 1'b1;
                    resp_q     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        wr_q  <= bus.ahb_write_in;
                        idx_q <= idx_d;
                        be_q  <= be_d;
                        cnt_q <= '0;
                        if (illegal) begin
                            state      <= S_ERR1;
                            readyout_q <= 1'b0;
                            resp_q     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state      <= S_WAIT;
                            readyout_q <= 1'b0;
                            resp_q     <= 1'b0;
                        end else begin
                            state      <= S_DATA;
                            readyout_q <= 1'b1;
                            resp_q     <= 1'b0;
                        end
                    end else begin
                        state      <= S_IDLE;
                        readyout_q <= 1'b1;
                        resp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- memory ----------------
    // Write commits at the end of the final data cycle, so a back-to-back
    // read of the same word sees it in its own DATA cycle.
    always_ff @(posedge ahb_clk_in) begin
        if (state == S_DATA && wr_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[b]) mem[idx_q][b] <= bus.ahb_wdata_in[8*b +: 8];
            end
        end
    end

    assign bus.slave_rdata_out    = (state == S_DATA && !wr_q) ? mem[idx_q] : rdata_q;
    assign bus.slave_readyout_out = readyout_q;
    assign bus.slave_resp_out     = resp_q;

endmodule
